// File: rtl/pc_seq_ctrl.sv
// Instruction-sequencing FSM: steers the PC input mux and raises the fetch,
// vector, extension-word and interrupt strobes for each instruction phase.
module pc_seq_ctrl #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
  parameter logic [15:0] IRQ_VEC_BASE = 16'hFFE0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dec_ext_cnt,
  input  logic        dec_is_jump,
  input  logic        jump_taken,
  input  logic        exec_done,
  input  logic        exec_pc_wr,
  input  logic        irq_pending,
  input  logic [3:0]  irq_num,
  input  logic        gie,
  input  logic        halt_req,
  input  logic        push_done,
  output logic [2:0]  pc_sel,
  output logic        mem_rd,
  output logic        vec_fetch,
  output logic [15:0] vec_addr,
  output logic        ir_load,
  output logic        ext_load,
  output logic        ext_idx,
  output logic        exec_en,
  output logic        irq_push,
  output logic        irq_ack,
  output logic [3:0]  dbg_state
);

  // Handshake note: there is no valid/ready pairing here. Every strobe is a
  // single-cycle qualifier decoded from the current state; the datapath acts
  // on it in the same cycle because memory reads are combinational.

  localparam logic [2:0] PC_MDB  = 3'd0;
  localparam logic [2:0] PC_CALC = 3'd2;
  localparam logic [2:0] PC_HOLD = 3'd3;
  localparam logic [2:0] PC_INC  = 3'd4;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXT    = 4'd3,
    S_EXEC   = 4'd4,
    S_JUMP   = 4'd5,
    S_IRQ    = 4'd6,
    S_VEC    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  state_t     state;
  state_t     state_next;
  state_t     boundary_state;
  logic [1:0] ext_cnt;
  logic [1:0] ext_cnt_next;
  logic       ext_pos;
  logic       ext_pos_next;
  logic [1:0] dec_cnt;
  logic       irq_take;

  assign dbg_state = state;

  // An encoding of 3 extension words is not legal; clamp it to 2.
  assign dec_cnt  = (dec_ext_cnt == 2'd3) ? 2'd2 : dec_ext_cnt;
  assign irq_take = irq_pending & gie;

  // Where control goes at an instruction boundary.
  always_comb begin
    boundary_state = S_FETCH;
    if (irq_take) begin
      boundary_state = S_IRQ;
    end else if (halt_req) begin
      boundary_state = S_HALT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RESET;
      ext_cnt <= 2'd0;
      ext_pos <= 1'b0;
    end else begin
      state   <= state_next;
      ext_cnt <= ext_cnt_next;
      ext_pos <= ext_pos_next;
    end
  end

  always_comb begin
    state_next   = state;
    ext_cnt_next = ext_cnt;
    ext_pos_next = ext_pos;
    pc_sel       = PC_HOLD;
    mem_rd       = 1'b0;
    vec_fetch    = 1'b0;
    vec_addr     = RESET_VECTOR;
    ir_load      = 1'b0;
    ext_load     = 1'b0;
    ext_idx      = 1'b0;
    exec_en      = 1'b0;
    irq_push     = 1'b0;
    irq_ack      = 1'b0;

    case (state)
      S_RESET: begin
        vec_fetch  = 1'b1;
        mem_rd     = 1'b1;
        pc_sel     = PC_MDB;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_rd     = 1'b1;
        ir_load    = 1'b1;
        pc_sel     = PC_INC;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Extension words are fetched even for jumps; EXEC then follows.
        if (dec_cnt != 2'd0) begin
          ext_cnt_next = dec_cnt;
          ext_pos_next = 1'b0;
          state_next   = S_EXT;
        end else if (dec_is_jump) begin
          state_next = S_JUMP;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXT: begin
        mem_rd       = 1'b1;
        ext_load     = 1'b1;
        ext_idx      = ext_pos;
        pc_sel       = PC_INC;
        ext_cnt_next = ext_cnt - 2'd1;
        ext_pos_next = 1'b1;
        if (ext_cnt <= 2'd1) begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if (exec_done) begin
          pc_sel     = exec_pc_wr ? PC_CALC : PC_HOLD;
          state_next = boundary_state;
        end
      end
      S_JUMP: begin
        pc_sel     = jump_taken ? PC_CALC : PC_HOLD;
        state_next = boundary_state;
      end
      S_IRQ: begin
        irq_push = 1'b1;
        if (push_done) begin
          state_next = S_VEC;
        end
      end
      S_VEC: begin
        vec_fetch  = 1'b1;
        vec_addr   = IRQ_VEC_BASE + {11'd0, irq_num, 1'b0};
        mem_rd     = 1'b1;
        pc_sel     = PC_MDB;
        irq_ack    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        // A wake-up interrupt beats a still-asserted halt request.
        if (irq_take) begin
          state_next = S_IRQ;
        end else if (!halt_req) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_RESET;
      end
    endcase

    // Outputs stay quiet for as long as reset is held.
    if (rst) begin
      pc_sel    = PC_HOLD;
      mem_rd    = 1'b0;
      vec_fetch = 1'b0;
      vec_addr  = RESET_VECTOR;
      ir_load   = 1'b0;
      ext_load  = 1'b0;
      ext_idx   = 1'b0;
      exec_en   = 1'b0;
      irq_push  = 1'b0;
      irq_ack   = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: instruction-level model builds the expected per-cycle
// output trace; ignored inputs are randomized every cycle.
module tb_pc_seq_ctrl;
  localparam int W = 27;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dec_ext_cnt;
  logic        dec_is_jump;
  logic        jump_taken;
  logic        exec_done;
  logic        exec_pc_wr;
  logic        irq_pending;
  logic [3:0]  irq_num;
  logic        gie;
  logic        halt_req;
  logic        push_done;
  logic [2:0]  pc_sel;
  logic        mem_rd;
  logic        vec_fetch;
  logic [15:0] vec_addr;
  logic        ir_load;
  logic        ext_load;
  logic        ext_idx;
  logic        exec_en;
  logic        irq_push;
  logic        irq_ack;
  logic [3:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [3:0]   st_q[$];

  pc_seq_ctrl dut (
    .clk(clk), .rst(rst), .dec_ext_cnt(dec_ext_cnt), .dec_is_jump(dec_is_jump),
    .jump_taken(jump_taken), .exec_done(exec_done), .exec_pc_wr(exec_pc_wr),
    .irq_pending(irq_pending), .irq_num(irq_num), .gie(gie), .halt_req(halt_req),
    .push_done(push_done), .pc_sel(pc_sel), .mem_rd(mem_rd), .vec_fetch(vec_fetch),
    .vec_addr(vec_addr), .ir_load(ir_load), .ext_load(ext_load), .ext_idx(ext_idx),
    .exec_en(exec_en), .irq_push(irq_push), .irq_ack(irq_ack), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Output word; the vector address only matters while vec_fetch is high.
  function automatic logic [W-1:0] pack(input logic [2:0] ps, input logic rd, input logic vf,
                                        input logic [15:0] va, input logic ir, input logic el,
                                        input logic ei, input logic ee, input logic ip,
                                        input logic ia);
    return {ps, rd, vf, (vf ? va : 16'h0000), ir, el, ei, ee, ip, ia};
  endfunction

  function automatic logic [W-1:0] idle();
    return pack(3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Driver tasks
  task automatic rand_inputs();
    dec_ext_cnt = 2'($urandom);
    dec_is_jump = 1'($urandom);
    jump_taken  = 1'($urandom);
    exec_done   = 1'($urandom);
    exec_pc_wr  = 1'($urandom);
    irq_pending = 1'($urandom);
    irq_num     = 4'($urandom);
    gie         = 1'($urandom);
    halt_req    = 1'($urandom);
    push_done   = 1'($urandom);
  endtask

  task automatic step(input logic [W-1:0] e);
    #1;
    exp_q.push_back(e);
    obs_q.push_back(pack(pc_sel, mem_rd, vec_fetch, vec_addr, ir_load, ext_load,
                         ext_idx, exec_en, irq_push, irq_ack));
    st_q.push_back(dbg_state);
  endtask

  // Reference model: one instruction from FETCH up to the next FETCH.
  task automatic run_instr(input logic [1:0] ext, input logic is_jump, input logic taken,
                           input int exec_len, input logic pc_wr, input logic irq,
                           input logic g, input logic [3:0] num, input logic halt,
                           input int push_len, input int halt_len, input logic exit_irq);
    int  n;
    logic take_irq;
    n = (ext > 2'd2) ? 2 : int'(ext);
    @(negedge clk); rand_inputs();
    step(pack(3'd4, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk); rand_inputs();
    dec_ext_cnt = ext;
    dec_is_jump = is_jump;
    step(idle());
    for (int i = 0; i < n; i++) begin
      @(negedge clk); rand_inputs();
      step(pack(3'd4, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, (i == 1), 1'b0, 1'b0, 1'b0));
    end
    if (is_jump && n == 0) begin
      @(negedge clk); rand_inputs();
      jump_taken = taken; irq_pending = irq; gie = g; halt_req = halt;
      step(pack(taken ? 3'd2 : 3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      for (int k = 0; k < exec_len; k++) begin
        @(negedge clk); rand_inputs();
        exec_done = (k == exec_len - 1);
        if (k == exec_len - 1) begin
          exec_pc_wr = pc_wr; irq_pending = irq; gie = g; halt_req = halt;
        end
        step(pack(((k == exec_len - 1) && pc_wr) ? 3'd2 : 3'd3, 1'b0, 1'b0, 16'h0,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      end
    end
    take_irq = irq & g;
    if (!take_irq && halt) begin
      for (int h = 0; h < halt_len; h++) begin
        @(negedge clk); rand_inputs();
        if (h < halt_len - 1) begin
          halt_req = 1'b1;
          gie = irq_pending ? 1'b0 : gie;
        end else if (exit_irq) begin
          irq_pending = 1'b1; gie = 1'b1;
        end else begin
          halt_req = 1'b0;
          gie = irq_pending ? 1'b0 : gie;
        end
        step(idle());
      end
      take_irq = exit_irq;
    end
    if (take_irq) begin
      for (int p = 0; p < push_len; p++) begin
        @(negedge clk); rand_inputs();
        push_done = (p == push_len - 1);
        step(pack(3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      end
      @(negedge clk); rand_inputs();
      irq_num = num;
      step(pack(3'd0, 1'b1, 1'b1, 16'hFFE0 + 16'(num) * 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] e, o;
    logic [3:0] s;
    int idx = 0;
    rst = 1'b1;
    rand_inputs();
    @(negedge clk); rand_inputs(); step(idle());
    checks++;
    if (vec_addr !== 16'hFFFE) begin
      errors++;
      $display("FAIL reset_vec_addr: got %h expected fffe", vec_addr);
    end
    @(negedge clk); rand_inputs(); rst = 1'b0;
    step(pack(3'd0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run_instr(2'd0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 1, 1'b0);
    // Now abort a two-word instruction during its first extension fetch.
    @(negedge clk); rand_inputs();
    step(pack(3'd4, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk); rand_inputs(); dec_ext_cnt = 2'd2;
    step(idle());
    @(negedge clk); rand_inputs();
    step(pack(3'd4, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 rst = 1'b1;
    step(idle());
    checks++;
    if (vec_addr !== 16'hFFFE) begin
      errors++;
      $display("FAIL reset_mid_vec_addr: got %h expected fffe", vec_addr);
    end
    @(negedge clk); rand_inputs(); step(idle());
    @(negedge clk); rand_inputs(); rst = 1'b0;
    step(pack(3'd0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run_instr(2'd1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1, 1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = st_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h expected %h (state %0d)", idx, o, e, s);
      end
      idx++;
    end
  endtask

  task automatic test_two_ext();
    logic [W-1:0] e, o;
    logic [3:0] s;
    int idx = 0;
    run_instr(2'd2, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 1, 1'b0);
    run_instr(2'd3, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1, 1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = st_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL two_ext cycle %0d: got %h expected %h (state %0d)", idx, o, e, s);
      end
      idx++;
    end
  endtask

  task automatic test_jump();
    logic [W-1:0] e, o;
    logic [3:0] s;
    int idx = 0;
    run_instr(2'd0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 1, 1'b0);
    run_instr(2'd0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 1, 1'b0);
    run_instr(2'd1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1, 1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = st_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jump cycle %0d: got %h expected %h (state %0d)", idx, o, e, s);
      end
      idx++;
    end
  endtask

  task automatic test_br();
    logic [W-1:0] e, o;
    logic [3:0] s;
    int idx = 0;
    run_instr(2'd0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1, 1, 1'b0);
    run_instr(2'd0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1, 1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = st_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL br cycle %0d: got %h expected %h (state %0d)", idx, o, e, s);
      end
      idx++;
    end
  endtask

  task automatic test_irq();
    logic [W-1:0] e, o;
    logic [3:0] s;
    int idx = 0;
    run_instr(2'd0, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 3, 1, 1'b0);
    run_instr(2'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 3, 1, 1'b0);
    run_instr(2'd0, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, 4'd15, 1'b1, 1, 1, 1'b0);
    run_instr(2'd2, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2, 1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = st_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL irq cycle %0d: got %h expected %h (state %0d)", idx, o, e, s);
      end
      idx++;
    end
  endtask

  task automatic test_halt();
    logic [W-1:0] e, o;
    logic [3:0] s;
    int idx = 0;
    run_instr(2'd0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 2, 10, 1'b1);
    run_instr(2'd0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1, 10, 1'b0);
    run_instr(2'd0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1, 1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = st_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt cycle %0d: got %h expected %h (state %0d)", idx, o, e, s);
      end
      idx++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, o;
    logic [3:0] s;
    int idx = 0;
    for (int t = 0; t < 60; t++) begin
      run_instr(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(1, 4),
                1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0), $urandom_range(1, 3), $urandom_range(1, 4),
                1'($urandom));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); s = st_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h (state %0d)", idx, o, e, s);
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_two_ext();
    test_jump();
    test_br();
    test_irq();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
